// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//
// Accumulates a batch of BATCH unsigned sums that arrive from an upstream
// adder. The finished total is then offered to a downstream consumer. Input
// and output each use a valid/ready handshake. While a completed total is
// held, the block stops accepting input. It resumes one cycle after the
// consumer takes the total.
//
// Parameters
//   SUM_W  width of the incoming sum, carry-out included as MSB (default 9)
//   ACC_W  accumulator width, legal range SUM_W..32             (default 16)
//   BATCH  samples per batch, legal range 1..15                 (default 8)
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   sum_in     unsigned sample from the upstream adder
//   sum_valid  sum_in holds a sample
//   sum_ready  block accepts a sample this cycle (state ACCUM)
//   acc_out    running total, or the completed batch total while in HOLD
//   acc_valid  acc_out holds a completed batch total (state HOLD)
//   acc_ready  consumer takes the completed total
//   overflow   sticky: the batch total has exceeded 2^ACC_W-1
//   count      samples accepted in the current batch
// -----------------------------------------------------------------------------
module sum_accumulator #(
    parameter int SUM_W = 9,
    parameter int ACC_W = 16,
    parameter int BATCH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic             sum_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             overflow,
    output logic [3:0]       count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [3:0] BATCH_CNT = 4'(BATCH);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc_next;
    logic             overflow_next;
    logic [3:0]       count_next;
    logic             accept;
    logic [ACC_W:0]   sum_wide;

    // Both handshake flags come from the state alone, so neither output
    // depends combinationally on any input.
    assign sum_ready = (state == ACCUM);
    assign acc_valid = (state == HOLD);
    assign accept    = sum_valid & sum_ready;

    // This sum is one bit wider than the accumulator. Its top bit is the
    // carry-out, which sets the sticky overflow flag.
    assign sum_wide = {1'b0, acc_out} + {{(ACC_W + 1 - SUM_W){1'b0}}, sum_in};

    // NOTE: every signal written here gets a default first. Then no path can
    // leave a signal unassigned, and no latch is inferred.
    always_comb begin
        state_next    = state;
        acc_next      = acc_out;
        overflow_next = overflow;
        count_next    = count;

        unique case (state)
            ACCUM: begin
                if (accept) begin
                    acc_next      = sum_wide[ACC_W-1:0];
                    overflow_next = overflow | sum_wide[ACC_W];
                    count_next    = count + 4'd1;
                    if (count_next == BATCH_CNT) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                // The release cycle accepts no input: sum_ready is low in
                // HOLD. That gives the one-cycle bubble before the next batch.
                if (acc_ready) begin
                    acc_next      = '0;
                    overflow_next = 1'b0;
                    count_next    = 4'd0;
                    state_next    = ACCUM;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments. Every register then
    // samples the pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACCUM;
            acc_out  <= '0;
            overflow <= 1'b0;
            count    <= 4'd0;
        end else begin
            state    <= state_next;
            acc_out  <= acc_next;
            overflow <= overflow_next;
            count    <= count_next;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
//
// Self-checking bench for sum_accumulator. It uses three instances:
//   d0  default parameters (SUM_W=9, ACC_W=16, BATCH=8)
//   d1  ACC_W=12, BATCH=15, to exercise wraparound and sticky overflow
//   d2  BATCH=1, where every accepted sample completes a batch
// The d0 reference model keeps the batch total as an unbounded integer.
// The expected acc_out is that total modulo 2^16. The expected overflow is
// whether the total has passed 65535.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance d0: defaults ----------------
    logic        reset0, valid0, ready_o0, aready0, avalid0, ovf0;
    logic [8:0]  sum0;
    logic [15:0] acc0;
    logic [3:0]  cnt0;

    sum_accumulator d0 (
        .clk(clk), .reset(reset0), .sum_in(sum0), .sum_valid(valid0),
        .sum_ready(ready_o0), .acc_out(acc0), .acc_valid(avalid0),
        .acc_ready(aready0), .overflow(ovf0), .count(cnt0)
    );

    // ---------------- instance d1: ACC_W=12, BATCH=15 ----------------
    logic        reset1, valid1, ready_o1, aready1, avalid1, ovf1;
    logic [8:0]  sum1;
    logic [11:0] acc1;
    logic [3:0]  cnt1;

    sum_accumulator #(.SUM_W(9), .ACC_W(12), .BATCH(15)) d1 (
        .clk(clk), .reset(reset1), .sum_in(sum1), .sum_valid(valid1),
        .sum_ready(ready_o1), .acc_out(acc1), .acc_valid(avalid1),
        .acc_ready(aready1), .overflow(ovf1), .count(cnt1)
    );

    // ---------------- instance d2: BATCH=1 ----------------
    logic        reset2, valid2, ready_o2, aready2, avalid2, ovf2;
    logic [8:0]  sum2;
    logic [15:0] acc2;
    logic [3:0]  cnt2;

    sum_accumulator #(.SUM_W(9), .ACC_W(16), .BATCH(1)) d2 (
        .clk(clk), .reset(reset2), .sum_in(sum2), .sum_valid(valid2),
        .sum_ready(ready_o2), .acc_out(acc2), .acc_valid(avalid2),
        .acc_ready(aready2), .overflow(ovf2), .count(cnt2)
    );

    // ---------------- d0 reference model ----------------
    localparam int BATCH0 = 8;
    longint m_total = 0;   // unbounded batch total
    int     m_cnt   = 0;
    bit     m_hold  = 1'b0;

    // Drive one cycle of d0 stimulus and advance the model by the same rules.
    // The task returns 1 time unit after the rising edge, when outputs are stable.
    task automatic step0(input logic rst, input logic v, input logic [8:0] s,
                         input logic ar);
        reset0  = rst;
        valid0  = v;
        sum0    = s;
        aready0 = ar;
        if (rst) begin
            m_total = 0; m_cnt = 0; m_hold = 1'b0;
        end else if (m_hold) begin
            if (ar) begin
                m_total = 0; m_cnt = 0; m_hold = 1'b0;
            end
        end else if (v) begin
            m_total += longint'(s);
            m_cnt++;
            if (m_cnt == BATCH0) m_hold = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] m_acc();
        return 16'(m_total % 65536);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        step0(1'b1, 1'b1, 9'd300, 1'b1);
        step0(1'b1, 1'b0, 9'd0, 1'b0);
        n_cmp++; if (acc0 !== 16'd0)  begin n_bad++; $display("FAIL reset_acc got=%0d exp=0", acc0); end
        n_cmp++; if (cnt0 !== 4'd0)   begin n_bad++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
        n_cmp++; if (avalid0 !== 1'b0) begin n_bad++; $display("FAIL reset_acc_valid got=%b exp=0", avalid0); end
        n_cmp++; if (ovf0 !== 1'b0)   begin n_bad++; $display("FAIL reset_overflow got=%b exp=0", ovf0); end
        n_cmp++; if (ready_o0 !== 1'b1) begin n_bad++; $display("FAIL reset_sum_ready got=%b exp=1", ready_o0); end
    endtask

    logic [8:0] stream [8] = '{9'd1, 9'd2, 9'd256, 9'd510, 9'd425, 9'd490, 9'd391, 9'd255};

    task automatic test_back_to_back();
        int total = 0;
        step0(1'b1, 1'b0, 9'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            total += int'(stream[i]);
            step0(1'b0, 1'b1, stream[i], 1'b1);
            n_cmp++; if (cnt0 !== 4'(i + 1)) begin n_bad++; $display("FAIL b2b_count i=%0d got=%0d exp=%0d", i, cnt0, i + 1); end
            if (i == 6) begin
                n_cmp++; if (avalid0 !== 1'b0) begin n_bad++; $display("FAIL b2b_early_valid got=%b exp=0", avalid0); end
            end
        end
        n_cmp++; if (acc0 !== 16'(total)) begin n_bad++; $display("FAIL b2b_acc got=%0d exp=%0d", acc0, total); end
        n_cmp++; if (acc0 !== 16'h091A)   begin n_bad++; $display("FAIL b2b_acc_const got=%h exp=091a", acc0); end
        n_cmp++; if (avalid0 !== 1'b1)    begin n_bad++; $display("FAIL b2b_valid got=%b exp=1", avalid0); end
        n_cmp++; if (ovf0 !== 1'b0)       begin n_bad++; $display("FAIL b2b_overflow got=%b exp=0", ovf0); end
        // This edge releases the total. The sample offered now must be ignored.
        step0(1'b0, 1'b1, 9'd77, 1'b1);
        n_cmp++; if (avalid0 !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_one_cycle got=%b exp=0", avalid0); end
        n_cmp++; if (acc0 !== 16'd0)   begin n_bad++; $display("FAIL b2b_acc_cleared got=%0d exp=0", acc0); end
        n_cmp++; if (cnt0 !== 4'd0)    begin n_bad++; $display("FAIL b2b_bubble_count got=%0d exp=0", cnt0); end
    endtask

    task automatic test_hold();
        step0(1'b1, 1'b0, 9'd0, 1'b0);
        for (int i = 0; i < 8; i++) step0(1'b0, 1'b1, stream[i], 1'b0);
        for (int k = 0; k < 5; k++) begin
            step0(1'b0, 1'b1, 9'd100, 1'b0);
            n_cmp++; if (acc0 !== 16'd2330)  begin n_bad++; $display("FAIL hold_acc k=%0d got=%0d exp=2330", k, acc0); end
            n_cmp++; if (ready_o0 !== 1'b0)  begin n_bad++; $display("FAIL hold_sum_ready k=%0d got=%b exp=0", k, ready_o0); end
            n_cmp++; if (cnt0 !== 4'd8)      begin n_bad++; $display("FAIL hold_count k=%0d got=%0d exp=8", k, cnt0); end
            n_cmp++; if (avalid0 !== 1'b1)   begin n_bad++; $display("FAIL hold_valid k=%0d got=%b exp=1", k, avalid0); end
        end
        step0(1'b0, 1'b0, 9'd0, 1'b1);
        n_cmp++; if (acc0 !== 16'd0) begin n_bad++; $display("FAIL hold_release_acc got=%0d exp=0", acc0); end
        step0(1'b0, 1'b1, 9'd4, 1'b0);
        n_cmp++; if (acc0 !== 16'd4) begin n_bad++; $display("FAIL hold_next_batch_acc got=%0d exp=4", acc0); end
        n_cmp++; if (cnt0 !== 4'd1)  begin n_bad++; $display("FAIL hold_next_batch_count got=%0d exp=1", cnt0); end
    endtask

    task automatic test_valid_toggle();
        step0(1'b1, 1'b0, 9'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step0(1'b0, (i % 2) == 0, 9'd1, 1'b0);
            n_cmp++; if (cnt0 !== 4'(m_cnt)) begin n_bad++; $display("FAIL toggle_count i=%0d got=%0d exp=%0d", i, cnt0, m_cnt); end
        end
        n_cmp++; if (acc0 !== 16'd8)    begin n_bad++; $display("FAIL toggle_acc got=%0d exp=8", acc0); end
        n_cmp++; if (avalid0 !== 1'b1)  begin n_bad++; $display("FAIL toggle_valid got=%b exp=1", avalid0); end
        step0(1'b0, 1'b0, 9'd0, 1'b1);
    endtask

    task automatic test_reset_mid();
        step0(1'b1, 1'b0, 9'd0, 1'b0);
        for (int i = 0; i < 4; i++) step0(1'b0, 1'b1, 9'($urandom_range(511)), 1'b0);
        step0(1'b1, 1'b1, 9'd200, 1'b1);
        n_cmp++; if (acc0 !== 16'd0)   begin n_bad++; $display("FAIL midreset_acc got=%0d exp=0", acc0); end
        n_cmp++; if (cnt0 !== 4'd0)    begin n_bad++; $display("FAIL midreset_count got=%0d exp=0", cnt0); end
        n_cmp++; if (avalid0 !== 1'b0) begin n_bad++; $display("FAIL midreset_valid got=%b exp=0", avalid0); end
        for (int i = 0; i < 8; i++) step0(1'b0, 1'b1, 9'd3, 1'b0);
        n_cmp++; if (acc0 !== 16'd24)  begin n_bad++; $display("FAIL midreset_acc24 got=%0d exp=24", acc0); end
        n_cmp++; if (avalid0 !== 1'b1) begin n_bad++; $display("FAIL midreset_valid24 got=%b exp=1", avalid0); end
        // Reset in HOLD discards the held total and wins over acc_ready.
        step0(1'b1, 1'b0, 9'd0, 1'b1);
        n_cmp++; if (avalid0 !== 1'b0) begin n_bad++; $display("FAIL holdreset_valid got=%b exp=0", avalid0); end
        n_cmp++; if (acc0 !== 16'd0)   begin n_bad++; $display("FAIL holdreset_acc got=%0d exp=0", acc0); end
        step0(1'b0, 1'b0, 9'd0, 1'b0);
        n_cmp++; if (avalid0 !== 1'b0) begin n_bad++; $display("FAIL holdreset_no_pulse got=%b exp=0", avalid0); end
    endtask

    task automatic test_random();
        step0(1'b1, 1'b0, 9'd0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            step0($urandom_range(39) == 0, $urandom_range(2) != 0,
                  9'($urandom_range(511)), $urandom_range(1) == 1);
            n_cmp++; if (acc0 !== m_acc())          begin n_bad++; $display("FAIL rand_acc c=%0d got=%0d exp=%0d", c, acc0, m_acc()); end
            n_cmp++; if (cnt0 !== 4'(m_cnt))        begin n_bad++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, cnt0, m_cnt); end
            n_cmp++; if (avalid0 !== m_hold)        begin n_bad++; $display("FAIL rand_acc_valid c=%0d got=%b exp=%b", c, avalid0, m_hold); end
            n_cmp++; if (ready_o0 !== !m_hold)      begin n_bad++; $display("FAIL rand_sum_ready c=%0d got=%b exp=%b", c, ready_o0, !m_hold); end
            n_cmp++; if (ovf0 !== (m_total > 65535)) begin n_bad++; $display("FAIL rand_overflow c=%0d got=%b exp=%b", c, ovf0, m_total > 65535); end
        end
    endtask

    task automatic test_overflow();
        int total = 0;
        reset1 = 1'b1; valid1 = 1'b0; sum1 = 9'd0; aready1 = 1'b0;
        @(posedge clk); #1;
        reset1 = 1'b0; valid1 = 1'b1; sum1 = 9'd511;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            total += 511;
            n_cmp++; if (acc1 !== 12'(total % 4096)) begin n_bad++; $display("FAIL ovf_acc i=%0d got=%0d exp=%0d", i, acc1, total % 4096); end
            n_cmp++; if (ovf1 !== (total > 4095))    begin n_bad++; $display("FAIL ovf_flag i=%0d got=%b exp=%b", i, ovf1, total > 4095); end
        end
        n_cmp++; if (acc1 !== 12'd3569) begin n_bad++; $display("FAIL ovf_final_acc got=%0d exp=3569", acc1); end
        n_cmp++; if (avalid1 !== 1'b1)  begin n_bad++; $display("FAIL ovf_valid got=%b exp=1", avalid1); end
        n_cmp++; if (cnt1 !== 4'd15)    begin n_bad++; $display("FAIL ovf_count got=%0d exp=15", cnt1); end
        // Valid stays high during HOLD. These samples must be ignored.
        @(posedge clk); #1;
        n_cmp++; if (acc1 !== 12'd3569) begin n_bad++; $display("FAIL ovf_hold_acc got=%0d exp=3569", acc1); end
        valid1 = 1'b0; aready1 = 1'b1;
        @(posedge clk); #1;
        aready1 = 1'b0;
        n_cmp++; if (ovf1 !== 1'b0)    begin n_bad++; $display("FAIL ovf_released got=%b exp=0", ovf1); end
        n_cmp++; if (acc1 !== 12'd0)   begin n_bad++; $display("FAIL ovf_release_acc got=%0d exp=0", acc1); end
        n_cmp++; if (avalid1 !== 1'b0) begin n_bad++; $display("FAIL ovf_release_valid got=%b exp=0", avalid1); end
    endtask

    task automatic test_batch_one();
        reset2 = 1'b1; valid2 = 1'b0; sum2 = 9'd0; aready2 = 1'b1;
        @(posedge clk); #1;
        reset2 = 1'b0; valid2 = 1'b1; sum2 = 9'd5;
        for (int k = 1; k <= 10; k++) begin
            logic exp_v;
            @(posedge clk); #1;
            exp_v = (k % 2) == 1;
            n_cmp++; if (avalid2 !== exp_v) begin n_bad++; $display("FAIL b1_valid k=%0d got=%b exp=%b", k, avalid2, exp_v); end
            n_cmp++; if (acc2 !== (exp_v ? 16'd5 : 16'd0)) begin n_bad++; $display("FAIL b1_acc k=%0d got=%0d exp=%0d", k, acc2, exp_v ? 5 : 0); end
            n_cmp++; if (cnt2 !== (exp_v ? 4'd1 : 4'd0))   begin n_bad++; $display("FAIL b1_count k=%0d got=%0d exp=%0d", k, cnt2, exp_v ? 1 : 0); end
        end
        valid2 = 1'b0;
    endtask

    initial begin
        reset0 = 1'b1; valid0 = 1'b0; sum0 = '0; aready0 = 1'b0;
        reset1 = 1'b1; valid1 = 1'b0; sum1 = '0; aready1 = 1'b0;
        reset2 = 1'b1; valid2 = 1'b0; sum2 = '0; aready2 = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_back_to_back();
        test_hold();
        test_valid_toggle();
        test_reset_mid();
        test_random();
        test_overflow();
        test_batch_one();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
